// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and owns the memory handshake with timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BRANCH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               load_q;
  logic               err_c;
  logic               retire_c;
  logic               timed_out;
  logic               taken;

  // funct7 is consumed by ALU control, not by the sequencer
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  assign timed_out = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      load_q      <= 1'b0;
      err         <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      err   <= err_c;
      if (retire_c)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (state == S_DECODE)
        load_q <= (opcode == OP_LOAD);
      // Counter restarts on every state change and after an abort back into FETCH
      if (state_next != state || err_c)
        wait_cnt <= '0;
      else if (mem_req && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    err_c      = 1'b0;
    retire_c   = 1'b0;
    taken      = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (timed_out) begin
          err_c      = 1'b1;
          state_next = S_FETCH;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:        state_next = S_EXEC;
          OP_LOAD, OP_STORE: state_next = S_ADDR;
          OP_BRANCH:         state_next = S_BRANCH;
          default: begin
            err_c      = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_op     = 2'b10;
        alu_src    = (opcode == OP_I);
        state_next = S_WB;
      end
      S_ADDR: begin
        alu_src    = 1'b1;
        state_next = S_MEM;
      end
      S_MEM: begin
        if (timed_out) begin
          err_c      = 1'b1;
          state_next = S_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = !load_q;
          alu_src = 1'b1;
          if (mem_ready) begin
            if (load_q) begin
              state_next = S_WB;
            end else begin
              retire_c   = 1'b1;
              state_next = S_FETCH;
            end
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = load_q;
        retire_c   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = 2'b01;
        state_next = S_FETCH;
        case (funct3)
          3'b000: begin taken = zero;  retire_c = 1'b1; end
          3'b001: begin taken = !zero; retire_c = 1'b1; end
          default: err_c = 1'b1;
        endcase
        pc_write = taken;
        pc_src   = taken;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
